// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned LOAD_LAT_DEF = 1;
  localparam int unsigned MUL_LAT_DEF  = 3;
  localparam int unsigned DIV_LAT_DEF  = 33;

  typedef enum logic {
    KIND_LOAD = 1'b0,
    KIND_MD   = 1'b1
  } kind_e;

  // Externally visible part of a slot; the countdown stays private to
  // hazard_slot because its width depends on the latency parameters.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    kind_e      kind;
  } hz_slot_t;

  // Countdown width needed to hold the largest of the three latencies.
  function automatic int unsigned cnt_width(input int unsigned lat_a,
                                            input int unsigned lat_b,
                                            input int unsigned lat_c);
    int unsigned m;
    m = lat_a;
    if (lat_b > m) m = lat_b;
    if (lat_c > m) m = lat_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One in-flight long-latency write: destination, class and remaining
// cycles until the result can be forwarded.
module hazard_slot
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  logic [4:0]       rd_i,
  input  kind_e            kind_i,
  input  logic [CNT_W-1:0] lat_i,
  input  logic [4:0]       rs1_i,
  input  logic             rs1_used_i,
  input  logic [4:0]       rs2_i,
  input  logic             rs2_used_i,
  output hz_slot_t         slot_o,
  output logic             match_o
);

  logic             valid_q, valid_d;
  logic [4:0]       rd_q, rd_d;
  kind_e            kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load on allocation (only offered while free), otherwise count down and
  // retire after the cycle in which the count reads one.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    if (alloc_i) begin
      valid_d = 1'b1;
      rd_d    = rd_i;
      kind_d  = kind_i;
      cnt_d   = lat_i;
    end else if (valid_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) valid_d = 1'b0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rd_q    <= 5'd0;
      kind_q  <= KIND_LOAD;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
    end
  end

  // Source-operand RAW match; x0 never matches.
  always_comb begin
    match_o = valid_q &
              ((rs1_used_i & (rs1_i != 5'd0) & (rs1_i == rd_q)) |
               (rs2_used_i & (rs2_i != 5'd0) & (rs2_i == rd_q)));
  end

  assign slot_o = '{valid: valid_q, rd: rd_q, kind: kind_q};

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: tracks long-latency writes, raises
// stall/bubble on RAW/WAW/structural hazards, lets EX redirects win.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NSLOT    = 4,
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
  parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  input  logic              id_is_div,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int unsigned CNT_W = cnt_width(LOAD_LAT, MUL_LAT, DIV_LAT);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  hz_slot_t         slot [NSLOT];
  logic [NSLOT-1:0] src_match;
  logic [NSLOT-1:0] slot_valid;
  logic [NSLOT-1:0] slot_md;
  logic [NSLOT-1:0] alloc;
  logic             found;
  logic             waw;
  logic             id_md;
  logic             long_lat;
  logic             any_free;
  logic             hazard;
  logic             issue;
  kind_e            new_kind;
  logic [CNT_W-1:0] new_lat;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    hazard_slot #(.CNT_W(CNT_W)) u_slot (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .alloc_i    (alloc[g]),
      .rd_i       (id_rd),
      .kind_i     (new_kind),
      .lat_i      (new_lat),
      .rs1_i      (id_rs1),
      .rs1_used_i (id_rs1_used),
      .rs2_i      (id_rs2),
      .rs2_used_i (id_rs2_used),
      .slot_o     (slot[g]),
      .match_o    (src_match[g])
    );
    assign slot_valid[g] = slot[g].valid;
    assign slot_md[g]    = slot[g].valid & (slot[g].kind == KIND_MD);
  end

  assign id_md    = id_is_mul | id_is_div;
  assign long_lat = id_we & (id_rd != 5'd0) & (id_is_load | id_md);
  assign any_free = ~&slot_valid;
  assign md_busy  = |slot_md;

  // Class of the instruction being allocated selects kind and countdown.
  always_comb begin
    new_kind = id_is_load ? KIND_LOAD : KIND_MD;
    new_lat  = id_is_load ? LOAD_CNT : (id_is_mul ? MUL_CNT : DIV_CNT);
  end

  // Destination check against every tracked rd (WAW).
  always_comb begin
    waw = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot[i].valid && id_we && (id_rd != 5'd0) && (slot[i].rd == id_rd)) waw = 1'b1;
    end
  end

  // Hazard reduction and redirect priority.
  always_comb begin
    hazard = id_valid & ((|src_match) | waw | (id_md & md_busy) | (long_lat & ~any_free));
    stall  = ~ex_redirect & hazard;
    bubble = ex_redirect | hazard;
    flush  = ex_redirect;
    issue  = id_valid & ~stall & ~ex_redirect;
  end

  // Allocate the lowest-index slot that was free at the start of the cycle.
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!slot_valid[i] && !found) begin
        alloc[i] = issue & long_lat;
        found    = 1'b1;
      end
    end
  end

  // Saturating stall-cycle count.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + PERF_W'(1);
  end

  // Perf counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: the driver computes expectations from a queue-based
// model of in-flight writes; a negedge monitor compares every cycle.
module tb_hazard_scoreboard;

  localparam int NSLOT    = 2;
  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 3;
  localparam int DIV_LAT  = 33;
  localparam int PERF_W   = 4;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_rs1_used, id_rs2_used, id_we;
  logic id_is_load, id_is_mul, id_is_div, ex_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic stall, bubble, flush, md_busy;
  logic [PERF_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NSLOT(NSLOT), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .id_is_mul(id_is_mul), .id_is_div(id_is_div), .ex_redirect(ex_redirect),
    .stall(stall), .bubble(bubble), .flush(flush), .md_busy(md_busy),
    .stall_cycles(stall_cycles)
  );

  typedef struct { logic [4:0] rd; bit md; int rem; } ent_t;
  typedef struct { logic stall, bubble, flush, md_busy; logic [PERF_W-1:0] sc; } exp_t;

  ent_t tbl[$];
  exp_t sb[$];
  exp_t mon_e;
  int   perf = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   m_stall, m_issue, d_stall;

  // Model: each entry lives for its latency in cycles after the issue cycle.
  task automatic cycle();
    bit raw, waw, mdb, mdi, ll, full, haz;
    exp_t e;
    ent_t ne;
    ent_t nxt[$];
    if (!rst_n) begin
      tbl.delete();
      perf = 0;
    end
    raw = 0; waw = 0; mdb = 0;
    foreach (tbl[i]) begin
      if (tbl[i].md) mdb = 1;
      if (id_rs1_used && id_rs1 != 0 && id_rs1 == tbl[i].rd) raw = 1;
      if (id_rs2_used && id_rs2 != 0 && id_rs2 == tbl[i].rd) raw = 1;
      if (id_we && id_rd != 0 && id_rd == tbl[i].rd) waw = 1;
    end
    mdi  = id_is_mul || id_is_div;
    ll   = id_we && id_rd != 0 && (id_is_load || mdi);
    full = tbl.size() >= NSLOT;
    haz  = id_valid && (raw || waw || (mdi && mdb) || (ll && full));
    m_stall = !ex_redirect && haz;
    m_issue = id_valid && !m_stall && !ex_redirect;
    e.stall = m_stall; e.bubble = ex_redirect || haz; e.flush = ex_redirect;
    e.md_busy = mdb; e.sc = PERF_W'(perf);
    sb.push_back(e);
    if (rst_n) begin
      foreach (tbl[i]) begin
        if (tbl[i].rem > 1) begin
          ne = tbl[i];
          ne.rem = ne.rem - 1;
          nxt.push_back(ne);
        end
      end
      if (m_issue && ll) begin
        ne.rd = id_rd;
        ne.md = mdi;
        ne.rem = id_is_load ? LOAD_LAT : (id_is_mul ? MUL_LAT : DIV_LAT);
        nxt.push_back(ne);
      end
      tbl = nxt;
      if (m_stall && perf < PERF_MAX) perf++;
    end
    #1 d_stall = stall;
    @(posedge clk);
    #1;
  endtask

  // cls: 0 alu, 1 load, 2 mul, 3 div
  task automatic set_ins(input bit v, input int cls, input int rd, input int rs1, input int rs2);
    id_valid = v; id_we = v; id_rs1_used = v; id_rs2_used = v;
    id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_is_load = v && cls == 1; id_is_mul = v && cls == 2; id_is_div = v && cls == 3;
  endtask

  task automatic idle(input int n);
    set_ins(0, 0, 0, 0, 0);
    repeat (n) cycle();
  endtask

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Hold the current ID instruction until it issues, counting DUT stalls.
  task automatic hold(input int max, input int exp_n, input string name);
    int n = 0;
    bit done = 0;
    for (int k = 0; k < max && !done; k++) begin
      cycle();
      if (d_stall) n++;
      if (m_issue) done = 1;
    end
    vectors++;
    if (!done || n != exp_n) begin
      miscompares++;
      $display("FAIL %s stalls_seen=%0d expected=%0d issued=%0d", name, n, exp_n, done);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        vectors++;
        if ({stall, bubble, flush, md_busy, stall_cycles} !==
            {mon_e.stall, mon_e.bubble, mon_e.flush, mon_e.md_busy, mon_e.sc}) begin
          miscompares++;
          $display("FAIL outputs t=%0t got s=%b b=%b f=%b md=%b sc=%0d exp s=%b b=%b f=%b md=%b sc=%0d",
                   $time, stall, bubble, flush, md_busy, stall_cycles,
                   mon_e.stall, mon_e.bubble, mon_e.flush, mon_e.md_busy, mon_e.sc);
        end
      end
    end
  end

  initial begin
    ex_redirect = 0;
    set_ins(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cycle(); cycle();
    rst_n = 1;
    idle(2);

    // load-use, then same with x0 sources
    set_ins(1, 1, 5, 1, 2); cycle();
    set_ins(1, 0, 6, 5, 1); hold(5, 1, "load_use");
    set_ins(1, 1, 5, 1, 2); cycle();
    set_ins(1, 0, 6, 0, 1); hold(5, 0, "load_use_x0");
    idle(2);

    // divide RAW, then structural div-after-div
    set_ins(1, 3, 7, 1, 2); cycle();
    set_ins(1, 0, 8, 7, 7); hold(40, 33, "div_raw");
    set_ins(1, 3, 10, 1, 2); cycle();
    set_ins(1, 3, 11, 1, 2); hold(40, 33, "div_struct");
    idle(40);

    // redirect while dependent is stalled; countdown carries on
    set_ins(1, 2, 9, 1, 2); cycle();
    set_ins(1, 0, 12, 9, 1); cycle();
    ex_redirect = 1; cycle();
    ex_redirect = 0; hold(5, 1, "after_redirect");
    idle(5);

    // table full with two slots
    set_ins(1, 2, 1, 0, 0); cycle();
    set_ins(1, 1, 2, 0, 0); cycle();
    set_ins(1, 1, 3, 0, 0); hold(5, 1, "table_full");
    idle(5);

    // async reset mid-division
    set_ins(1, 3, 7, 1, 2); cycle();
    set_ins(1, 0, 8, 7, 7); repeat (5) cycle();
    rst_n = 0;
    #1;
    check("rst_md_busy", int'(md_busy), 0);
    check("rst_stall_cycles", int'(stall_cycles), 0);
    cycle();
    rst_n = 1;
    hold(5, 0, "post_reset_issue");

    // perf saturation
    set_ins(1, 3, 7, 1, 2); cycle();
    set_ins(1, 0, 8, 7, 7); repeat (20) cycle();
    check("perf_saturate", int'(stall_cycles), PERF_MAX);
    idle(20);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int cls;
      rst_n = ($urandom_range(0, 299) != 0);
      cls = $urandom_range(0, 5);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rd       = 5'($urandom_range(0, 7));
      id_rs1_used = $urandom_range(0, 1);
      id_rs2_used = $urandom_range(0, 1);
      id_we       = ($urandom_range(0, 3) != 0);
      id_is_load  = (cls == 3);
      id_is_mul   = (cls == 4);
      id_is_div   = (cls == 5);
      ex_redirect = ($urandom_range(0, 9) == 0);
      cycle();
    end
    rst_n = 1;
    ex_redirect = 0;
    idle(2);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
